argmax_label: RTL and testbench

ARGMAX_LABEL -- requirements
Module: argmax_label

---
 rtl/argmax_label.sv | 214 +++++++++++++++++++++
 tb/tb_argmax_label.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_label.sv
// argmax_label
// Picks the highest-scoring class channel for every pixel using a registered
// pairwise-compare tree. Enable and coordinates travel alongside the tree so
// every output is aligned. A per-class histogram of the winning labels is kept
// for each frame and published at frame end.
module argmax_label #(
  parameter int W_WIDTH   = -1,
  parameter int W_HEIGHT  = -1,
  parameter int INT_BITW  = -1,
  parameter int FRAC_BITW = -1,
  parameter int UNITS     = -1,
  parameter int CNT_BITW  = 20,
  // Parameters left at their -1 sentinel fall back to minimal legal widths,
  // so the module still elaborates on its own.
  localparam int UNITS_C    = (UNITS < 1) ? 1 : UNITS,
  localparam int FIXED_BITW = (INT_BITW + FRAC_BITW < 1) ? 1 : INT_BITW + FRAC_BITW,
  localparam int H_BITW     = (W_WIDTH < 2) ? 1 : $clog2(W_WIDTH),
  localparam int V_BITW     = (W_HEIGHT < 2) ? 1 : $clog2(W_HEIGHT),
  localparam int L_BITW     = (UNITS_C < 2) ? 1 : $clog2(UNITS_C)
) (
  input  logic                           clock,
  input  logic                           n_rst,
  input  logic                           in_enable,
  input  logic [FIXED_BITW*UNITS_C-1:0]  in_pixels,
  input  logic [V_BITW-1:0]              in_vcnt,
  input  logic [H_BITW-1:0]              in_hcnt,
  output logic                           out_enable,
  output logic [L_BITW-1:0]              out_label,
  output logic [FIXED_BITW-1:0]          out_score,
  output logic [V_BITW-1:0]              out_vcnt,
  output logic [H_BITW-1:0]              out_hcnt,
  output logic                           hist_valid,
  output logic [CNT_BITW*UNITS_C-1:0]    hist
);

  localparam int LEVELS  = $clog2(UNITS_C);
  localparam int LATENCY = LEVELS + 1;

  localparam logic [H_BITW-1:0]   H_LAST  = H_BITW'(W_WIDTH - 1);
  localparam logic [V_BITW-1:0]   V_LAST  = V_BITW'(W_HEIGHT - 1);
  localparam logic [CNT_BITW-1:0] CNT_MAX = '1;

  // Number of candidates alive after 'level' rounds of pairing.
  function automatic int node_count(input int level);
    return (UNITS_C + (1 << level) - 1) >> level;
  endfunction

  logic signed [FIXED_BITW-1:0] tree_score;
  logic        [L_BITW-1:0]     tree_label;

  // ---------------------------------------------------------------------------
  // Compare tree: one register stage per level.
  // ---------------------------------------------------------------------------
  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_level
    localparam int N_IN  = node_count(lv);
    localparam int N_OUT = node_count(lv + 1);

    logic signed [FIXED_BITW-1:0] src_score [N_IN];
    logic        [L_BITW-1:0]     src_label [N_IN];

    if (lv == 0) begin : g_src_in
      for (genvar k = 0; k < N_IN; k++) begin : g_ch
        assign src_score[k] = $signed(in_pixels[k*FIXED_BITW +: FIXED_BITW]);
        assign src_label[k] = L_BITW'(k);
      end
    end else begin : g_src_prev
      for (genvar k = 0; k < N_IN; k++) begin : g_ch
        assign src_score[k] = g_level[lv-1].g_node[k].node_score;
        assign src_label[k] = g_level[lv-1].g_node[k].node_label;
      end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_node
      logic signed [FIXED_BITW-1:0] node_score;
      logic        [L_BITW-1:0]     node_label;

      if (2*j + 1 < N_IN) begin : g_pair
        // Keep the lower-index operand unless the upper one is strictly larger.
        always_ff @(posedge clock or negedge n_rst) begin
          if (!n_rst) begin
            node_score <= '0;
            node_label <= '0;
          end else if (src_score[2*j+1] > src_score[2*j]) begin
            node_score <= src_score[2*j+1];
            node_label <= src_label[2*j+1];
          end else begin
            node_score <= src_score[2*j];
            node_label <= src_label[2*j];
          end
        end
      end else begin : g_pass
        // An unpaired candidate moves up one level unchanged.
        always_ff @(posedge clock or negedge n_rst) begin
          if (!n_rst) begin
            node_score <= '0;
            node_label <= '0;
          end else begin
            node_score <= src_score[2*j];
            node_label <= src_label[2*j];
          end
        end
      end
    end
  end

  if (LEVELS == 0) begin : g_flat
    assign tree_score = $signed(in_pixels[FIXED_BITW-1:0]);
    assign tree_label = '0;
  end else begin : g_root
    assign tree_score = g_level[LEVELS-1].g_node[0].node_score;
    assign tree_label = g_level[LEVELS-1].g_node[0].node_label;
  end

  // Final output register for the winning label and score.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      out_label <= '0;
      out_score <= '0;
    end else begin
      out_label <= tree_label;
      out_score <= tree_score;
    end
  end

  // ---------------------------------------------------------------------------
  // Side-band delay line, same depth as the tree plus output register.
  // primed_pipe marks output slots that hold real post-reset input.
  // ---------------------------------------------------------------------------
  logic              en_pipe     [LATENCY];
  logic              primed_pipe [LATENCY];
  logic [V_BITW-1:0] vcnt_pipe   [LATENCY];
  logic [H_BITW-1:0] hcnt_pipe   [LATENCY];

  // Shift enable, coordinates and the primed marker along with the tree.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        en_pipe[i]     <= 1'b0;
        primed_pipe[i] <= 1'b0;
        vcnt_pipe[i]   <= '0;
        hcnt_pipe[i]   <= '0;
      end
    end else begin
      en_pipe[0]     <= in_enable;
      primed_pipe[0] <= 1'b1;
      vcnt_pipe[0]   <= in_vcnt;
      hcnt_pipe[0]   <= in_hcnt;
      for (int i = 1; i < LATENCY; i++) begin
        en_pipe[i]     <= en_pipe[i-1];
        primed_pipe[i] <= primed_pipe[i-1];
        vcnt_pipe[i]   <= vcnt_pipe[i-1];
        hcnt_pipe[i]   <= hcnt_pipe[i-1];
      end
    end
  end

  assign out_enable = en_pipe[LATENCY-1];
  assign out_vcnt   = vcnt_pipe[LATENCY-1];
  assign out_hcnt   = hcnt_pipe[LATENCY-1];

  // ---------------------------------------------------------------------------
  // Histogram. A frame is only published if its first position was seen
  // after reset, so a frame cut by reset never produces hist_valid.
  // ---------------------------------------------------------------------------
  logic [CNT_BITW-1:0] counts      [UNITS_C];
  logic [CNT_BITW-1:0] counts_next [UNITS_C];
  logic                seen_start;
  logic                frame_start;
  logic                frame_end;

  assign frame_start = primed_pipe[LATENCY-1] && (out_vcnt == '0) && (out_hcnt == '0);
  assign frame_end   = out_enable && (out_vcnt == V_LAST) && (out_hcnt == H_LAST);

  // Saturating increment of the counter belonging to the current label.
  always_comb begin
    for (int k = 0; k < UNITS_C; k++) begin
      counts_next[k] = counts[k];
      if (out_enable && (out_label == L_BITW'(k)) && (counts[k] != CNT_MAX)) begin
        counts_next[k] = counts[k] + CNT_BITW'(1);
      end
    end
  end

  // Accumulate per frame, publish and clear at frame end.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < UNITS_C; k++) begin
        counts[k] <= '0;
      end
      hist       <= '0;
      hist_valid <= 1'b0;
      seen_start <= 1'b0;
    end else begin
      hist_valid <= 1'b0;
      if (frame_start) begin
        seen_start <= 1'b1;
      end
      if (frame_end) begin
        for (int k = 0; k < UNITS_C; k++) begin
          counts[k] <= '0;
          if (seen_start) begin
            hist[k*CNT_BITW +: CNT_BITW] <= counts_next[k];
          end
        end
        hist_valid <= seen_start;
      end else begin
        for (int k = 0; k < UNITS_C; k++) begin
          counts[k] <= counts_next[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_argmax_label.sv
// tb_argmax_label
// Streams frames into two argmax_label instances (wide and 3-bit counters)
// and scores every aligned output and every histogram against a reference
// model held in queues.
module tb_argmax_label;

  localparam int UNITS     = 4;
  localparam int INT_BITW  = 4;
  localparam int FRAC_BITW = 4;
  localparam int W_WIDTH   = 8;
  localparam int W_HEIGHT  = 4;
  localparam int LATENCY   = 3;
  localparam int MAIN_BITW = 20;
  localparam int SAT_BITW  = 3;

  logic        clock;
  logic        n_rst;
  logic        in_enable;
  logic [31:0] in_pixels;
  logic [1:0]  in_vcnt;
  logic [2:0]  in_hcnt;

  logic        out_enable;
  logic [1:0]  out_label;
  logic [7:0]  out_score;
  logic [1:0]  out_vcnt;
  logic [2:0]  out_hcnt;
  logic        hist_valid;
  logic [79:0] hist;

  logic        s_out_enable;
  logic [1:0]  s_out_label;
  logic [7:0]  s_out_score;
  logic [1:0]  s_out_vcnt;
  logic [2:0]  s_out_hcnt;
  logic        s_hist_valid;
  logic [11:0] s_hist;

  typedef struct {
    int         label;
    logic [7:0] score;
    logic [1:0] vcnt;
    logic [2:0] hcnt;
    int         due;
  } pix_exp_t;

  typedef struct {
    logic [3:0][7:0] counts;
    int              due;
  } hist_exp_t;

  pix_exp_t  pix_q[$];
  hist_exp_t hist_q[$];

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int model_counts[4];
  bit started;
  int v_pos;
  int h_pos;

  argmax_label #(
    .W_WIDTH(W_WIDTH), .W_HEIGHT(W_HEIGHT), .INT_BITW(INT_BITW),
    .FRAC_BITW(FRAC_BITW), .UNITS(UNITS), .CNT_BITW(MAIN_BITW)
  ) dut (
    .clock(clock), .n_rst(n_rst), .in_enable(in_enable), .in_pixels(in_pixels),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(out_enable),
    .out_label(out_label), .out_score(out_score), .out_vcnt(out_vcnt),
    .out_hcnt(out_hcnt), .hist_valid(hist_valid), .hist(hist)
  );

  argmax_label #(
    .W_WIDTH(W_WIDTH), .W_HEIGHT(W_HEIGHT), .INT_BITW(INT_BITW),
    .FRAC_BITW(FRAC_BITW), .UNITS(UNITS), .CNT_BITW(SAT_BITW)
  ) dut_sat (
    .clock(clock), .n_rst(n_rst), .in_enable(in_enable), .in_pixels(in_pixels),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_enable(s_out_enable),
    .out_label(s_out_label), .out_score(s_out_score), .out_vcnt(s_out_vcnt),
    .out_hcnt(s_out_hcnt), .hist_valid(s_hist_valid), .hist(s_hist)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counter used to time when each expected output is due.
  always @(posedge clock) cycle <= cycle + 1;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Index of the first channel holding the largest signed score.
  function automatic int ref_label(input logic [31:0] px);
    int vals[4];
    int best;
    int idx;
    for (int k = 0; k < 4; k++) vals[k] = int'($signed(px[k*8 +: 8]));
    best = vals[0];
    for (int k = 1; k < 4; k++) if (vals[k] > best) best = vals[k];
    idx = 0;
    for (int k = 3; k >= 0; k--) if (vals[k] == best) idx = k;
    return idx;
  endfunction

  function automatic int sat(input int c, input int bits);
    int m;
    m = (1 << bits) - 1;
    return (c > m) ? m : c;
  endfunction

  function automatic logic [79:0] pack_hist(input logic [3:0][7:0] c, input int bits);
    logic [79:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r = r | (80'(sat(int'(c[k]), bits)) << (k * bits));
    return r;
  endfunction

  // Drive one raster position and record what the model expects from it.
  task automatic applyStimulus(input logic en, input logic [31:0] px);
    pix_exp_t  pe;
    hist_exp_t he;
    int        lbl;
    @(negedge clock);
    in_enable = en;
    in_pixels = px;
    in_vcnt   = 2'(v_pos);
    in_hcnt   = 3'(h_pos);
    lbl = ref_label(px);
    if (v_pos == 0 && h_pos == 0) started = 1'b1;
    if (en) begin
      pe.label = lbl;
      pe.score = px[lbl*8 +: 8];
      pe.vcnt  = 2'(v_pos);
      pe.hcnt  = 3'(h_pos);
      pe.due   = cycle + LATENCY;
      pix_q.push_back(pe);
      model_counts[lbl]++;
      if (v_pos == W_HEIGHT - 1 && h_pos == W_WIDTH - 1) begin
        if (started) begin
          for (int k = 0; k < 4; k++) he.counts[k] = 8'(model_counts[k]);
          he.due = cycle + LATENCY + 1;
          hist_q.push_back(he);
        end
        for (int k = 0; k < 4; k++) model_counts[k] = 0;
      end
    end
    h_pos++;
    if (h_pos == W_WIDTH) begin
      h_pos = 0;
      v_pos = (v_pos + 1) % W_HEIGHT;
    end
  endtask

  // mode 0 random, 1 directed vectors, 2 class2x20/class0x12, 3 ten class-1 pixels, 4 idle
  task automatic runFrame(input int mode, input int from_idx, input int to_idx);
    for (int idx = from_idx; idx <= to_idx; idx++) begin
      logic        en;
      logic [31:0] px;
      px = $urandom();
      if ($urandom_range(0, 3) == 0) px[15:8] = px[7:0];
      if ($urandom_range(0, 5) == 0) px[31:24] = px[23:16];
      en = ($urandom_range(0, 3) != 0) || (idx == 31);
      case (mode)
        1: begin
          if (idx == 0) px = 32'hF0203010;
          if (idx == 1) px = 32'hFFF880F8;
          if (idx == 2) px = 32'h20102020;
          if (idx <= 2 || idx == 21 || idx == 31) en = 1'b1;
        end
        2: begin
          en = 1'b1;
          px = (idx < 20) ? 32'h20400010 : 32'h30201050;
        end
        3: begin
          if (idx < 10) begin
            en = 1'b1;
            px = 32'h00107000;
          end else if (idx == 31) begin
            en = 1'b1;
            px = 32'h40000000;
          end else begin
            en = 1'b0;
          end
        end
        4: en = 1'b0;
        default: ;
      endcase
      applyStimulus(en, px);
    end
  endtask

  task automatic resetZeroChecks();
    checkOutput("rst_main_pipe", {out_enable, out_label, out_score, out_vcnt, out_hcnt}, '0);
    checkOutput("rst_main_hist", {hist_valid, hist}, '0);
    checkOutput("rst_sat_all", {s_out_enable, s_out_label, s_out_score, s_out_vcnt,
                                s_out_hcnt, s_hist_valid, s_hist}, '0);
  endtask

  task automatic flushModel();
    pix_q.delete();
    hist_q.delete();
    for (int k = 0; k < 4; k++) model_counts[k] = 0;
    started = 1'b0;
  endtask

  // Monitor: pops expectations when they fall due and compares.
  initial begin : monitor
    pix_exp_t    pe;
    hist_exp_t   he;
    logic [79:0] hold_main;
    logic [79:0] hold_sat;
    bit          exp_en;
    bit          exp_hv;
    hold_main = '0;
    hold_sat  = '0;
    forever begin
      @(posedge clock);
      #1;
      if (!n_rst) begin
        hold_main = '0;
        hold_sat  = '0;
      end else begin
        exp_en = (pix_q.size() > 0) && (pix_q[0].due == cycle);
        checkOutput("out_enable", out_enable, exp_en);
        checkOutput("sat_out_enable", s_out_enable, exp_en);
        if (exp_en) begin
          pe = pix_q.pop_front();
          checkOutput("out_label", out_label, pe.label);
          checkOutput("out_score", out_score, pe.score);
          checkOutput("out_vcnt", out_vcnt, pe.vcnt);
          checkOutput("out_hcnt", out_hcnt, pe.hcnt);
          checkOutput("sat_out_label", s_out_label, pe.label);
        end
        exp_hv = (hist_q.size() > 0) && (hist_q[0].due == cycle);
        if (exp_hv) begin
          he = hist_q.pop_front();
          hold_main = pack_hist(he.counts, MAIN_BITW);
          hold_sat  = pack_hist(he.counts, SAT_BITW);
        end
        checkOutput("hist_valid", hist_valid, exp_hv);
        checkOutput("sat_hist_valid", s_hist_valid, exp_hv);
        checkOutput("hist", hist, hold_main);
        checkOutput("sat_hist", s_hist, hold_sat);
      end
    end
  end

  // Stimulus sequence.
  initial begin : stimulus
    n_rst     = 1'b1;
    in_enable = 1'b0;
    in_pixels = '0;
    in_vcnt   = 2'd3;
    in_hcnt   = 3'd6;
    v_pos     = 0;
    h_pos     = 0;
    flushModel();
    #2;
    n_rst = 1'b0;
    #1;
    resetZeroChecks();
    @(negedge clock);
    @(negedge clock);
    n_rst = 1'b1;

    runFrame(1, 0, 31);
    runFrame(2, 0, 31);
    runFrame(3, 0, 31);
    runFrame(0, 0, 31);
    runFrame(0, 0, 31);

    // Reset in the middle of a frame; the rest of that frame must not publish.
    runFrame(0, 0, 12);
    @(negedge clock);
    n_rst     = 1'b0;
    in_enable = 1'b0;
    flushModel();
    #1;
    resetZeroChecks();
    @(negedge clock);
    @(negedge clock);
    n_rst = 1'b1;
    runFrame(0, 13, 31);
    runFrame(0, 0, 31);

    runFrame(4, 0, 5);
    repeat (3) @(negedge clock);
    checkOutput("pix_queue_drained", pix_q.size(), 0);
    checkOutput("hist_queue_drained", hist_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
